// File: rtl/axi_lite_driver.sv
// axi_lite_driver: single-outstanding AXI4-Lite master behind a simple
// command/response handshake. Writes present AW and W together and retire each
// channel on its own handshake. Reads go AR then R. Every completion produces
// one registered rsp_valid_o pulse from the DONE state.
// Optional build macro: AXI_LITE_DRIVER_TIMEOUT_EN adds a per-state response
// timeout of TIMEOUT_CYCLES cycles that completes the command with SLVERR.
module axi_lite_driver #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // command side
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  // response side
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [1:0]      rsp_resp_o,
  output logic            rsp_err_o,
  // AXI-Lite write address
  output logic [AW-1:0]   aw_addr_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  // AXI-Lite write data
  output logic [DW-1:0]   w_data_o,
  output logic [DW/8-1:0] w_strb_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  // AXI-Lite write response
  input  logic [1:0]      b_resp_i,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  // AXI-Lite read address
  output logic [AW-1:0]   ar_addr_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  // AXI-Lite read data
  input  logic [DW-1:0]   r_data_i,
  input  logic [1:0]      r_resp_i,
  input  logic            r_valid_i,
  output logic            r_ready_o
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    DONE         = 3'd5
  } state_e;

  state_e        state_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          aw_done_r;
  logic          w_done_r;
  logic          aw_hs_s;
  logic          w_hs_s;
  logic          timeout_s;

  // The address and data registers are only loaded in IDLE, so they stay
  // stable for as long as any valid that presents them is high.
  assign aw_addr_o = addr_r;
  assign ar_addr_o = addr_r;
  assign w_data_o  = wdata_r;
  assign w_strb_o  = {(DW/8){1'b1}};

  assign aw_hs_s = aw_valid_o && aw_ready_i;
  assign w_hs_s  = w_valid_o && w_ready_i;

`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e        prev_state_r;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] count_s;
  logic          busy_s;

  // A state change shows up as state_r differing from its one-cycle-old copy.
  // That marks the first cycle in the new state, where the count restarts at 0.
  assign count_s   = (state_r != prev_state_r) ? {TW{1'b0}} : timer_r;
  assign busy_s    = (state_r == WR_ADDR_DATA) || (state_r == WR_RESP) ||
                     (state_r == RD_ADDR)      || (state_r == RD_DATA);
  assign timeout_s = busy_s && (count_s == TW'(TIMEOUT_CYCLES - 1));

  // Count the cycles spent in the current state. Wrapping in IDLE or DONE is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_state_r <= IDLE;
      timer_r      <= {TW{1'b0}};
    end else begin
      prev_state_r <= state_r;
      timer_r      <= count_s + TW'(1);
    end
  end
`else
  // The timeout is not built in. This flag stays constant-false so the driver
  // waits indefinitely, and it still references the parameter.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Transaction FSM. All handshake and response outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cmd_ready_o <= 1'b1;
      aw_valid_o  <= 1'b0;
      w_valid_o   <= 1'b0;
      b_ready_o   <= 1'b0;
      ar_valid_o  <= 1'b0;
      r_ready_o   <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      addr_r      <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= {DW{1'b0}};
      rsp_resp_o  <= 2'b00;
      rsp_err_o   <= 1'b0;
    end else if (timeout_s) begin
      // The slave stalled too long. Drop every handshake and complete with SLVERR.
      state_r     <= DONE;
      aw_valid_o  <= 1'b0;
      w_valid_o   <= 1'b0;
      b_ready_o   <= 1'b0;
      ar_valid_o  <= 1'b0;
      r_ready_o   <= 1'b0;
      rsp_valid_o <= 1'b1;
      rsp_rdata_o <= {DW{1'b0}};
      rsp_resp_o  <= 2'b10;
      rsp_err_o   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          // A stray b_valid or r_valid is ignored here.
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o <= 1'b0;
            addr_r      <= cmd_addr_i;
            if (cmd_we_i) begin
              wdata_r    <= cmd_wdata_i;
              aw_valid_o <= 1'b1;
              w_valid_o  <= 1'b1;
              aw_done_r  <= 1'b0;
              w_done_r   <= 1'b0;
              state_r    <= WR_ADDR_DATA;
            end else begin
              ar_valid_o <= 1'b1;
              state_r    <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          // Each channel retires on its own handshake. Both may retire in one cycle.
          if (aw_hs_s) begin
            aw_valid_o <= 1'b0;
            aw_done_r  <= 1'b1;
          end
          if (w_hs_s) begin
            w_valid_o <= 1'b0;
            w_done_r  <= 1'b1;
          end
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            b_ready_o <= 1'b1;
            state_r   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_valid_i) begin
            b_ready_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= {DW{1'b0}};
            rsp_resp_o  <= b_resp_i;
            rsp_err_o   <= (b_resp_i != 2'b00);
            state_r     <= DONE;
          end
        end
        RD_ADDR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            r_ready_o  <= 1'b1;
            state_r    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_valid_i) begin
            r_ready_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= r_data_i;
            rsp_resp_o  <= r_resp_i;
            rsp_err_o   <= (r_resp_i != 2'b00);
            state_r     <= DONE;
          end
        end
        DONE: begin
          // The response pulse lasts one cycle. Accepting a new command waits
          // for IDLE, so acceptance and response never share a cycle.
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_o <= 1'b1;
          aw_valid_o  <= 1'b0;
          w_valid_o   <= 1'b0;
          b_ready_o   <= 1'b0;
          ar_valid_o  <= 1'b0;
          r_ready_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_driver.sv
// Directed self-checking bench for axi_lite_driver. The slave side is driven
// step by step from the single initial block.
module tb_axi_lite_driver;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic            rsp_valid, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   aw_addr, ar_addr;
  logic            aw_valid, aw_ready, w_valid, w_ready;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic [1:0]      b_resp, r_resp;
  logic            b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready;
  logic [DW-1:0]   r_data;
  logic [7:0]      flags;

  int vectors = 0;
  int miscompares = 0;
  int n;

  axi_lite_driver #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp),
    .rsp_err_o(rsp_err),
    .aw_addr_o(aw_addr), .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(w_data), .w_strb_o(w_strb), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .ar_addr_o(ar_addr), .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
    .r_data_i(r_data), .r_resp_i(r_resp), .r_valid_i(r_valid), .r_ready_o(r_ready)
  );

  always #5 clk = ~clk;

  assign flags = {cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid, rsp_err};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until rsp_valid is seen or max edges have elapsed.
  task automatic wait_rsp(input int max, output int cnt);
    cnt = 0;
    while (rsp_valid !== 1'b1 && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk("reset_flags", flags, 8'b1000_0000);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_resp", rsp_resp, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_flags", flags, 8'b1000_0000);

    // write 0x8000 / 7, slave always ready: AW+W in the same cycle, 3-cycle latency
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
    send(1'b1, 32'h8000, 32'h7);
    chk("t1_aw_w_valid", {aw_valid, w_valid, cmd_ready}, 3'b110);
    chk("t1_aw_addr", aw_addr, 32'h8000);
    chk("t1_w_data", w_data, 32'h7);
    chk("t1_w_strb", w_strb, 4'hf);
    tick();
    chk("t1_wr_resp", {aw_valid, w_valid, b_ready, rsp_valid}, 4'b0010);
    tick();
    chk("t1_rsp", {rsp_valid, rsp_err, rsp_resp, b_ready, cmd_ready}, 6'b100000);
    chk("t1_rdata", rsp_rdata, 32'h0);
    b_valid = 1'b0;
    tick();
    chk("t1_back_idle", {rsp_valid, cmd_ready}, 2'b01);

    // write 0x10, aw_ready delayed 4 cycles, w_ready immediate
    aw_ready = 1'b0; w_ready = 1'b1;
    send(1'b1, 32'h10, 32'ha5a5_0001);
    chk("t2_both_valid", {aw_valid, w_valid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_aw_hold", {aw_valid, w_valid, b_ready}, 3'b100);
      chk("t2_aw_addr", aw_addr, 32'h10);
    end
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    chk("t2_wr_resp", {aw_valid, w_valid, b_ready, rsp_valid}, 4'b0010);
    tick();
    chk("t2_b_wait", {b_ready, rsp_valid}, 2'b10);
    b_valid = 1'b1; b_resp = 2'b00;
    tick();
    b_valid = 1'b0;
    chk("t2_rsp", {rsp_valid, rsp_err, rsp_resp}, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_single_rsp", rsp_valid, 1'b0);
    end

    // stray b_valid/r_valid in IDLE are ignored, then read 0x1000
    b_valid = 1'b1; r_valid = 1'b1; r_data = 32'hff00_1000; r_resp = 2'b00; ar_ready = 1'b1;
    tick();
    chk("t3_stray", flags, 8'b1000_0000);
    send(1'b0, 32'h1000, 32'h0);
    chk("t3_ar", {ar_valid, r_ready, aw_valid, b_ready}, 4'b1000);
    chk("t3_ar_addr", ar_addr, 32'h1000);
    tick();
    chk("t3_rd_data", {ar_valid, r_ready}, 2'b01);
    tick();
    chk("t3_rsp", {rsp_valid, rsp_err, rsp_resp, b_ready, cmd_ready}, 6'b100000);
    chk("t3_rdata", rsp_rdata, 32'hff00_1000);
    b_valid = 1'b0; r_valid = 1'b0;
    tick();
    chk("t3_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'hff00_1000});

    // read answered with SLVERR
    send(1'b0, 32'h2000, 32'h0);
    tick();
    chk("t4_r_wait", {ar_valid, r_ready, rsp_valid}, 3'b010);
    r_valid = 1'b1; r_resp = 2'b10; r_data = 32'hdead_beef;
    tick();
    r_valid = 1'b0; r_resp = 2'b00;
    chk("t4_rsp", {rsp_valid, rsp_err, rsp_resp}, 4'b1110);
    chk("t4_rdata", rsp_rdata, 32'hdead_beef);
    tick();

    // write answered with DECERR: error flagged, rdata cleared
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b11;
    send(1'b1, 32'h20, 32'h55);
    wait_rsp(10, n);
    chk("t5_latency", n, 2);
    chk("t5_rsp", {rsp_err, rsp_resp}, 3'b111);
    chk("t5_rdata", rsp_rdata, 32'h0);
    b_valid = 1'b0; b_resp = 2'b00;
    tick();

    // reset while in WR_RESP: everything drops asynchronously, no response
    send(1'b1, 32'h30, 32'h99);
    tick();
    chk("t6_in_wr_resp", {b_ready, rsp_valid}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", flags, 8'b1000_0000);
    b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("t6_no_rsp", flags, 8'b1000_0000);
    chk("t6_rsp_cleared", {rsp_resp, rsp_rdata}, 34'h0);
    b_valid = 1'b0;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h1234_5678; r_resp = 2'b00;
    send(1'b0, 32'h3000, 32'h0);
    wait_rsp(10, n);
    chk("t6_next_latency", n, 2);
    chk("t6_next_rsp", {rsp_err, rsp_resp, rsp_rdata}, {3'b000, 32'h1234_5678});
    r_valid = 1'b0;
    tick();

`ifdef AXI_LITE_DRIVER_TIMEOUT_EN
    // slave never answers B: timeout after 16 cycles in WR_RESP
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0;
    send(1'b1, 32'h40, 32'h1);
    tick();
    aw_ready = 1'b0; w_ready = 1'b0;
    chk("t7_wr_resp", b_ready, 1'b1);
    wait_rsp(40, n);
    chk("t7_timeout_cycles", n, 16);
    chk("t7_rsp", {rsp_valid, rsp_err, rsp_resp, b_ready}, 5'b11100);
    chk("t7_rdata", rsp_rdata, 32'h0);
    tick();
    chk("t7_idle", flags, 8'b1000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
